pix_ram_arbiter: RTL and testbench
==================================

// Module: pix_ram_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single read-only image RAM (ram36x3_1, 1-cycle read latency) between the
//  star edge finders (top/bottom, left, right). Each finder presents an (x,y) pixel request and receives a
//  one-hot grant. The requested pixel comes back one cycle later, tagged with a per-requester valid.
//  Sits between the finder datapaths and the RAM. Replaces the per-finder RAM/address-translator copies.
// PARAMETERS
//  N_REQ    3  number of requesters (>=2)
//  XSZ      3  x coordinate width
//  YSZ      3  y coordinate width
//  ADDR_SZ  6  RAM address width
//  COL_SZ   3  pixel value width
//  WIDTH    6  image width in pixels (row stride)
//  HEIGHT   6  image height in pixels
// PORTS
//  clk       in   1            system clock, all state on posedge
//  reset     in   1            synchronous, active-high reset
//  req       in   N_REQ        req[i]=1: requester i wants pixel (x_in[i],y_in[i]); held until gnt[i]
//  x_in      in   N_REQ*XSZ    packed x coords, requester i at [i*XSZ +: XSZ]
//  y_in      in   N_REQ*YSZ    packed y coords, requester i at [i*YSZ +: YSZ]
//  gnt       out  N_REQ        one-hot (or zero) grant, combinational, same cycle as accepted req
//  rd_valid  out  N_REQ        one-hot: rd_data belongs to requester i this cycle
//  rd_data   out  COL_SZ       returned pixel value (shared bus)
//  rd_oor    out  1            qualifies rd_valid: coordinate was out of range
//  ram_addr  out  ADDR_SZ      address to RAM, driven in the grant cycle
//  ram_q     in   COL_SZ       RAM read data, valid one cycle after ram_addr
// BEHAVIOUR
//  - Clock and reset:
//    - Clock clk. Reset reset is synchronous and active-high.
//    - Reset values: rr_ptr=0, p_valid=0, p_owner=0, p_oor=0.
//    - Hence after reset rd_valid=0, rd_oor=0, and requester 0 has top priority.
//  - Arbitration (combinational, cycle t):
//    - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//    - gnt[winner]=1, all other gnt bits 0. No req -> gnt=0, ram_addr=0.
//    - gnt is forced to 0 while reset=1.
//  - Pointer update: on a grant, rr_ptr <= (winner+1) mod N_REQ. With no grant, rr_ptr holds.
//    - Worst-case wait under continuous contention is N_REQ-1 grants.
//  - Throughput: one grant per cycle, fully pipelined.
//    - A requester may hold req with new coordinates on the cycle after its grant and is re-eligible immediately.
//  - Address: ram_addr = y*WIDTH + x, computed unsigned at ADDR_SZ bits (zero-extend operands, no signed add).
//    - Example: (5,5) -> 35.
//  - Range check: x>=WIDTH or y>=HEIGHT -> out of range.
//    - Still granted. ram_addr forced to 0.
//    - Next cycle rd_data=0 (black, reads as an edge), rd_oor=1.
//  - Latency: grant at cycle t -> at cycle t+1 rd_valid[winner]=1 and rd_data=ram_q (0 if oor).
//    - Pipeline regs: p_valid, p_owner, p_oor.
//  - Data gating: rd_valid=0 -> rd_data=0, rd_oor=0.
//  - Reset mid-operation: a grant issued in the reset cycle is not possible.
//    - A read granted at t with reset=1 at t+1's edge is discarded: no rd_valid, rr_ptr returns to 0.
//  - req deasserted without grant: legal, no side effects. Coordinates are only sampled in the grant cycle.
//  - RAM write-enable is tied 0 at the instantiating level. This block never writes.
// STRUCTURE
//  - Shared package/header: IMG_WIDTH=6, IMG_HEIGHT=6, XSZ, YSZ, ADDR_SZ, COL_SZ, PIX_THRESHOLD=0.
//    - The finders use the same constants.
//  - Sub-module: pix_addr_calc (x,y -> addr plus oor flag, parameterised by WIDTH/HEIGHT).
//  - Arbiter, pointer and return pipeline stay inline. RAM is instantiated outside.
// TESTING  (bench models the RAM as 1-cycle registered, mem[a]=a%8)
//  1. Reset, then req=001 with (x=2,y=3) -> gnt=001 same cycle, ram_addr=20.
//     Next cycle rd_valid=001, rd_data=4, rd_oor=0.
//  2. After reset, req=111 held 6 cycles -> gnt sequence 001,010,100,001,010,100.
//     rd_valid follows one cycle behind.
//  3. rr_ptr=0, req=110 -> gnt=010 then (req=100) gnt=100. Requester 0 joining later waits at most 2 grants.
//  4. Requester 2 at (x=6,y=0) -> gnt=100, ram_addr=0. Next cycle rd_valid=100, rd_data=0, rd_oor=1.
//  5. Grant to requester 1 at t, reset=1 at t+1 -> rd_valid=000 at t+1.
//     After release, req=111 -> gnt=001 first.
//  6. Requester 0 at (5,5) -> ram_addr=35, rd_data=3. Also (0,0) -> ram_addr=0, rd_oor=0.

Source files
------------

// File: rtl/pix_ram_arbiter_pkg.sv
// Shared image geometry and bus widths for the edge finders and the RAM arbiter.
package pix_ram_arbiter_pkg;
  localparam int IMG_WIDTH     = 6;
  localparam int IMG_HEIGHT    = 6;
  localparam int XSZ           = 3;
  localparam int YSZ           = 3;
  localparam int ADDR_SZ       = 6;
  localparam int COL_SZ        = 3;
  localparam int PIX_THRESHOLD = 0;

  typedef logic [COL_SZ-1:0]  pix_t;
  typedef logic [ADDR_SZ-1:0] addr_t;
endpackage

// File: rtl/pix_addr_calc.sv
// Maps an (x,y) pixel coordinate to a row-major RAM address; out-of-range coordinates flag oor and yield address 0.
module pix_addr_calc
  import pix_ram_arbiter_pkg::*;
#(
  parameter int WIDTH   = IMG_WIDTH,
  parameter int HEIGHT  = IMG_HEIGHT,
  parameter int X_W     = XSZ,
  parameter int Y_W     = YSZ,
  parameter int ADDR_W  = ADDR_SZ
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              oor
);

  assign oor  = (int'(x) >= WIDTH) || (int'(y) >= HEIGHT);
  // Operands are zero-extended to the address width so the product never goes signed.
  assign addr = oor ? '0 : (ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x));

endmodule

// File: rtl/pix_ram_arbiter.sv
// Round-robin share of the single image RAM between the edge finders; grant is combinational,
// pixel data returns one cycle later tagged with a one-hot per-requester valid.
module pix_ram_arbiter
  import pix_ram_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int X_W     = XSZ,
  parameter int Y_W     = YSZ,
  parameter int ADDR_W  = ADDR_SZ,
  parameter int COL_W   = COL_SZ,
  parameter int WIDTH   = IMG_WIDTH,
  parameter int HEIGHT  = IMG_HEIGHT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*X_W-1:0] x_in,
  input  logic [N_REQ*Y_W-1:0] y_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rd_valid,
  output logic [COL_W-1:0]     rd_data,
  output logic                 rd_oor,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [COL_W-1:0]     ram_q
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  next_ptr;
  logic              found;
  logic              any_gnt;
  int                idx;
  logic [X_W-1:0]    sel_x;
  logic [Y_W-1:0]    sel_y;
  logic [ADDR_W-1:0] calc_addr;
  logic              calc_oor;

  logic              p_valid;
  logic [PTR_W-1:0]  p_owner;
  logic              p_oor;

  // Scan from the round-robin pointer and take the first requester found.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  assign any_gnt  = found && !reset;
  assign gnt      = any_gnt ? (N_REQ'(1) << winner) : '0;
  assign next_ptr = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  assign sel_x = x_in[winner*X_W +: X_W];
  assign sel_y = y_in[winner*Y_W +: Y_W];

  pix_addr_calc #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .x    (sel_x),
    .y    (sel_y),
    .addr (calc_addr),
    .oor  (calc_oor)
  );

  assign ram_addr = any_gnt ? calc_addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      p_valid <= 1'b0;
      p_owner <= '0;
      p_oor   <= 1'b0;
    end else begin
      if (any_gnt) begin
        rr_ptr <= next_ptr;
      end
      p_valid <= any_gnt;
      p_owner <= winner;
      p_oor   <= calc_oor;
    end
  end

  // The return stage is also masked by reset so a read in flight when reset rises is dropped at once.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    rd_oor   = 1'b0;
    if (p_valid && !reset) begin
      rd_valid = N_REQ'(1) << p_owner;
      rd_oor   = p_oor;
      rd_data  = p_oor ? '0 : ram_q;
    end
  end

endmodule

// File: tb/tb_pix_ram_arbiter.sv
// Directed bench for pix_ram_arbiter with a 1-cycle registered RAM holding mem[a] = a % 8.
module tb_pix_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [8:0] x_in;
  logic [8:0] y_in;
  logic [2:0] gnt;
  logic [2:0] rd_valid;
  logic [2:0] rd_data;
  logic       rd_oor;
  logic [5:0] ram_addr;
  logic [2:0] ram_q;

  int checks = 0;
  int errors = 0;

  int gseq [6] = '{1, 2, 4, 1, 2, 4};
  int dseq [6] = '{7, 0, 1, 7, 0, 1};

  pix_ram_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .x_in     (x_in),
    .y_in     (y_in),
    .gnt      (gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_oor   (rd_oor),
    .ram_addr (ram_addr),
    .ram_q    (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= ram_addr[2:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b111;
    x_in  = '0;
    y_in  = '0;
    tick();
    @(negedge clk);
    chk("gnt_in_reset", 32'(gnt), 0);
    chk("rdv_in_reset", 32'(rd_valid), 0);
    tick();
    reset = 1'b0;
    req   = 3'b000;
    @(negedge clk);
    chk("rdv_after_reset", 32'(rd_valid), 0);
    chk("oor_after_reset", 32'(rd_oor), 0);
    chk("gnt_idle", 32'(gnt), 0);
    chk("addr_idle", 32'(ram_addr), 0);

    // 1: single request at (2,3)
    tick();
    req  = 3'b001;
    x_in = {3'd0, 3'd0, 3'd2};
    y_in = {3'd0, 3'd0, 3'd3};
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_addr", 32'(ram_addr), 20);
    tick();
    req = 3'b000;
    @(negedge clk);
    chk("t1_rdv", 32'(rd_valid), 1);
    chk("t1_data", 32'(rd_data), 4);
    chk("t1_oor", 32'(rd_oor), 0);

    // 2: full contention after reset; requester i at (i+1,1)
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 3'b111;
    x_in  = {3'd3, 3'd2, 3'd1};
    y_in  = {3'd1, 3'd1, 3'd1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_gnt", 32'(gnt), gseq[k]);
      if (k > 0) begin
        chk("t2_rdv", 32'(rd_valid), gseq[k-1]);
        chk("t2_data", 32'(rd_data), dseq[k-1]);
      end
      tick();
    end
    req = 3'b000;
    @(negedge clk);
    chk("t2_rdv_last", 32'(rd_valid), 4);
    chk("t2_data_last", 32'(rd_data), 1);

    // 3: rotation from pointer 0, then requester 0 joins late
    tick();
    req = 3'b110;
    @(negedge clk);
    chk("t3_gnt_a", 32'(gnt), 2);
    tick();
    req = 3'b100;
    @(negedge clk);
    chk("t3_gnt_b", 32'(gnt), 4);
    tick();
    req = 3'b110;
    @(negedge clk);
    chk("t3_join_a", 32'(gnt), 2);
    tick();
    req = 3'b111;
    @(negedge clk);
    chk("t3_join_b", 32'(gnt), 4);
    tick();
    @(negedge clk);
    chk("t3_join_c", 32'(gnt), 1);

    // 4: requester 2 out of range in x
    tick();
    req  = 3'b100;
    x_in = {3'd6, 3'd0, 3'd0};
    y_in = {3'd0, 3'd0, 3'd0};
    @(negedge clk);
    chk("t4_gnt", 32'(gnt), 4);
    chk("t4_addr", 32'(ram_addr), 0);
    tick();
    req = 3'b000;
    @(negedge clk);
    chk("t4_rdv", 32'(rd_valid), 4);
    chk("t4_data", 32'(rd_data), 0);
    chk("t4_oor", 32'(rd_oor), 1);

    // 5: reset lands while a read is in flight
    tick();
    req  = 3'b010;
    x_in = {3'd0, 3'd3, 3'd0};
    y_in = {3'd0, 3'd1, 3'd0};
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 2);
    chk("t5_addr", 32'(ram_addr), 9);
    tick();
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);
    chk("t5_rdv_dropped", 32'(rd_valid), 0);
    chk("t5_data_dropped", 32'(rd_data), 0);
    tick();
    reset = 1'b0;
    req   = 3'b111;
    @(negedge clk);
    chk("t5_gnt_after", 32'(gnt), 1);
    chk("t5_rdv_after", 32'(rd_valid), 0);

    // 6: corner coordinates for requester 0
    tick();
    req  = 3'b001;
    x_in = {3'd0, 3'd0, 3'd5};
    y_in = {3'd0, 3'd0, 3'd5};
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 1);
    chk("t6_addr_55", 32'(ram_addr), 35);
    tick();
    x_in = '0;
    y_in = '0;
    @(negedge clk);
    chk("t6_rdv_55", 32'(rd_valid), 1);
    chk("t6_data_55", 32'(rd_data), 3);
    chk("t6_addr_00", 32'(ram_addr), 0);
    tick();
    req  = 3'b010;
    x_in = {3'd0, 3'd0, 3'd0};
    y_in = {3'd0, 3'd6, 3'd0};
    @(negedge clk);
    chk("t6_rdv_00", 32'(rd_valid), 1);
    chk("t6_oor_00", 32'(rd_oor), 0);
    chk("t6_gnt_yoor", 32'(gnt), 2);
    chk("t6_addr_yoor", 32'(ram_addr), 0);
    tick();
    req = 3'b000;
    @(negedge clk);
    chk("t6_rdv_yoor", 32'(rd_valid), 2);
    chk("t6_oor_yoor", 32'(rd_oor), 1);
    tick();
    @(negedge clk);
    chk("t6_rdv_idle", 32'(rd_valid), 0);
    chk("t6_oor_idle", 32'(rd_oor), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
